agent_config_loader: RTL and testbench
======================================

AGENT_CONFIG_LOADER -- requirements
Module: agent_config_loader

Interface
REQ-001 Parameter NUM_AGENTS, default 100, number of agents on the configuration bus.
REQ-002 Parameter CONN_WORDS, default ceil(NUM_AGENTS/32) = 4, number of 32-bit connectivity words per agent.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s_valid  input  1  host word valid.
REQ-006 s_ready  output  1  loader accepts host word; transfer when s_valid & s_ready on a rising edge.
REQ-007 s_data  input  32  host word: a header, or a payload word.
REQ-008 address  output  32  target agent address, zero-extended from header[15:0].
REQ-009 seed_value  output  32  seed word for the addressed agent.
REQ-010 load_seed  output  1  one-cycle seed load strobe.
REQ-011 init_state  output  1  initial infection state: 0 = SUS, 1 = INF.
REQ-012 load_state  output  1  one-cycle state load strobe.
REQ-013 val_connectivity  output  32  connectivity word.
REQ-014 load_connectivity  output  1  one-cycle connectivity word strobe.
REQ-015 run_en  output  1  simulation advance enable.
REQ-016 busy  output  1  high whenever FSM is not IDLE.
REQ-017 err  output  1  sticky address-range error flag.

Function
REQ-018 Header format: [31:30] opcode (0 SEED, 1 STATE, 2 CONN, 3 RUN); [16] state bit; [15:0] agent address, or cycle count for RUN.
REQ-019 FSM states: IDLE, SEED, CONN, RUN.
REQ-020 s_ready SHALL be 1 in IDLE, SEED and CONN, and 0 in RUN and during reset.
REQ-021 IDLE, SEED header accepted: latch address; go to SEED.
REQ-022 SEED, payload accepted: next cycle seed_value = payload, load_seed = 1 for exactly one cycle; go to IDLE.
REQ-023 IDLE, STATE header accepted: next cycle init_state = header[16], load_state = 1 for one cycle; stay in IDLE.
REQ-024 IDLE, CONN header accepted: latch address; clear the 0..CONN_WORDS-1 word counter; go to CONN.
REQ-025 CONN, each payload accepted: next cycle val_connectivity = word, load_connectivity = 1 for one cycle; counter increments.
REQ-026 CONN: after word CONN_WORDS-1 is accepted, counter wraps to 0 and FSM goes to IDLE; exactly CONN_WORDS strobes are issued per command.
REQ-027 address SHALL hold stable from the header until the last strobe of the command.
REQ-028 RUN header with count N>0: run_en = 1 for exactly N consecutive cycles, starting the cycle after acceptance; then IDLE. Count N=0: no run_en pulse, FSM stays in IDLE.
REQ-029 Payload gaps (s_valid low) SHALL stall the FSM indefinitely, with no strobes issued.
REQ-030 At most one of load_seed, load_state and load_connectivity is high in any cycle.
REQ-031 Back-to-back commands: a header accepted the cycle after a command completes is processed with no bubble.

Reset
REQ-032 On rst_n low, all of the following SHALL be 0 asynchronously: FSM = IDLE, counters, address, seed_value, val_connectivity, init_state, all strobes, run_en, busy and err.
REQ-033 A reset in the middle of CONN SHALL abandon the command, and no further strobes are issued.
REQ-034 The host SHALL resend the full command after reset.

Configuration
REQ-035 Macro LOADER_ADDR_CHECK_EN.
REQ-036 With LOADER_ADDR_CHECK_EN defined: a SEED, STATE or CONN header with address >= NUM_AGENTS still has its payload consumed, but issues no strobes and sets err; only reset clears err.
REQ-037 Without LOADER_ADDR_CHECK_EN: no range check is made, and err is tied to 0.

Verification
REQ-038 SEED header addr 5, then payload 0xDEADBEEF -> address = 5, one load_seed pulse with seed_value = 0xDEADBEEF, busy low afterwards.
REQ-039 STATE header addr 7 with bit16 = 1 -> one load_state pulse with init_state = 1 and address = 7; s_ready stays 1.
REQ-040 CONN header addr 3, then 4 words 0x1..0x4 with s_valid gaps of 2 cycles -> exactly 4 load_connectivity pulses, values in order, address = 3 throughout.
REQ-041 RUN header count 10 -> run_en high for exactly 10 cycles and s_ready low for those cycles; RUN with count 0 -> no run_en pulse.
REQ-042 rst_n low after the 2nd CONN word -> all outputs 0 at once; a fresh CONN command then yields exactly 4 pulses.
REQ-043 With LOADER_ADDR_CHECK_EN defined: SEED header addr 100 and its payload -> no load_seed pulse, err = 1 and stays 1.

Source files
------------

// File: rtl/agent_config_loader.sv
// ---------------------------------------------------------------------------
// agent_config_loader
//
// Receives a stream of 32-bit host words (headers followed by payload words)
// and turns them into per-agent configuration strobes for an agent array:
// seed words, initial infection state, and connectivity bitmap words. A RUN
// header instead opens a window of run_en cycles during which the loader
// accepts no host words.
//
// Header layout:
//   [31:30] opcode  0 = SEED, 1 = STATE, 2 = CONN, 3 = RUN
//   [16]    initial state bit (STATE only)
//   [15:0]  agent address, or cycle count for RUN
//
// Ports:
//   clk                in   single clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   s_valid            in   host word valid
//   s_ready            out  loader can take a host word (transfer on valid & ready)
//   s_data      [31:0] in   host word
//   address     [31:0] out  target agent, zero-extended from header[15:0]
//   seed_value  [31:0] out  seed word, qualified by load_seed
//   load_seed          out  one-cycle seed strobe
//   init_state         out  initial state (0 = SUS, 1 = INF), qualified by load_state
//   load_state         out  one-cycle state strobe
//   val_connectivity [31:0] out  connectivity word, qualified by load_connectivity
//   load_connectivity  out  one-cycle connectivity strobe
//   run_en             out  simulation advance enable
//   busy               out  FSM not idle
//   err                out  sticky address-range error
//
// Build option:
//   LOADER_ADDR_CHECK_EN  when defined, SEED/STATE/CONN headers addressing an
//                         agent >= NUM_AGENTS have their payload consumed but
//                         raise no strobe, and set err until the next reset.
//                         When undefined, err is tied low and every address
//                         is accepted.
// ---------------------------------------------------------------------------
module agent_config_loader #(
    parameter int NUM_AGENTS = 100,
    parameter int CONN_WORDS = (NUM_AGENTS + 31) / 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic [31:0] address,
    output logic [31:0] seed_value,
    output logic        load_seed,
    output logic        init_state,
    output logic        load_state,
    output logic [31:0] val_connectivity,
    output logic        load_connectivity,
    output logic        run_en,
    output logic        busy,
    output logic        err
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = (CONN_WORDS > 1) ? $clog2(CONN_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONN_WORDS - 1);

    localparam logic [1:0] OP_SEED  = 2'd0;
    localparam logic [1:0] OP_STATE = 2'd1;
    localparam logic [1:0] OP_CONN  = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_CONN = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Header field views of the incoming word.
    logic [1:0]  hdr_op;
    logic        hdr_st;
    logic [15:0] hdr_arg;
    logic        accept;
    logic        hdr_ok;

    // Command context held across the payload words.
    logic [CNT_W-1:0] conn_cnt_q;
    logic [15:0]      run_cnt_q;
    logic             cmd_ok_q;

    // Registered output stage.
    logic [DATA_W-1:0] address_p1;
    logic [DATA_W-1:0] seed_value_p1;
    logic [DATA_W-1:0] val_conn_p1;
    logic              init_state_p1;
    logic              load_seed_p1;
    logic              load_state_p1;
    logic              load_conn_p1;

    logic unused_hdr_bits;

    assign hdr_op          = s_data[31:30];
    assign hdr_st          = s_data[16];
    assign hdr_arg         = s_data[15:0];
    assign accept          = s_valid & s_ready;
    assign unused_hdr_bits = ^s_data[29:17];

`ifdef LOADER_ADDR_CHECK_EN
    logic err_q;
    logic hdr_bad;

    assign hdr_ok  = ({16'd0, hdr_arg} < 32'(NUM_AGENTS));
    // Only addressed commands are range checked; RUN carries a count.
    assign hdr_bad = accept && (state_q == ST_IDLE) && (hdr_op != OP_RUN) && !hdr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (hdr_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign hdr_ok = 1'b1;
    assign err    = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (hdr_op)
                        OP_SEED:  state_d = ST_SEED;
                        OP_CONN:  state_d = ST_CONN;
                        // A zero count is a no-op: stay ready for the next header.
                        OP_RUN:   state_d = (hdr_arg != 16'd0) ? ST_RUN : ST_IDLE;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SEED: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONN: begin
                if (accept && (conn_cnt_q == CNT_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // run_cnt_q holds the cycles left including the current one.
                if (run_cnt_q <= 16'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from the current state
    // -----------------------------------------------------------------------
    always_comb begin
        // rst_n gates ready so no word is taken while reset is held.
        s_ready = rst_n && (state_q != ST_RUN);
        busy    = (state_q != ST_IDLE);
        run_en  = (state_q == ST_RUN);
    end

    // -----------------------------------------------------------------------
    // Stage p1: command context and registered strobes/data, one cycle after
    // the word that produced them was accepted.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conn_cnt_q    <= '0;
            run_cnt_q     <= '0;
            cmd_ok_q      <= 1'b0;
            address_p1    <= '0;
            seed_value_p1 <= '0;
            val_conn_p1   <= '0;
            init_state_p1 <= 1'b0;
            load_seed_p1  <= 1'b0;
            load_state_p1 <= 1'b0;
            load_conn_p1  <= 1'b0;
        end else begin
            load_seed_p1  <= 1'b0;
            load_state_p1 <= 1'b0;
            load_conn_p1  <= 1'b0;

            if (accept) begin
                case (state_q)
                    ST_IDLE: begin
                        case (hdr_op)
                            OP_SEED: begin
                                address_p1 <= {16'd0, hdr_arg};
                                cmd_ok_q   <= hdr_ok;
                            end
                            OP_STATE: begin
                                address_p1 <= {16'd0, hdr_arg};
                                if (hdr_ok) begin
                                    init_state_p1 <= hdr_st;
                                    load_state_p1 <= 1'b1;
                                end
                            end
                            OP_CONN: begin
                                address_p1 <= {16'd0, hdr_arg};
                                cmd_ok_q   <= hdr_ok;
                                conn_cnt_q <= '0;
                            end
                            default: begin
                                // RUN leaves address untouched; only the count is kept.
                                run_cnt_q <= hdr_arg;
                            end
                        endcase
                    end
                    ST_SEED: begin
                        if (cmd_ok_q) begin
                            seed_value_p1 <= s_data;
                            load_seed_p1  <= 1'b1;
                        end
                    end
                    ST_CONN: begin
                        if (cmd_ok_q) begin
                            val_conn_p1  <= s_data;
                            load_conn_p1 <= 1'b1;
                        end
                        conn_cnt_q <= (conn_cnt_q == CNT_LAST) ? '0 : conn_cnt_q + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end else if (state_q == ST_RUN) begin
                run_cnt_q <= run_cnt_q - 16'd1;
            end
        end
    end

    assign address           = address_p1;
    assign seed_value        = seed_value_p1;
    assign load_seed         = load_seed_p1;
    assign init_state        = init_state_p1;
    assign load_state        = load_state_p1;
    assign val_connectivity  = val_conn_p1;
    assign load_connectivity = load_conn_p1;

endmodule

// File: tb/tb_agent_config_loader.sv
// ---------------------------------------------------------------------------
// Testbench for agent_config_loader. Expected strobe events are queued as the
// host words are driven; a monitor on the falling edge pops and compares them
// against every strobe and run_en cycle the loader produces.
// Build option LOADER_ADDR_CHECK_EN selects the address-range scenario.
// ---------------------------------------------------------------------------
module tb_agent_config_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'd0;
    logic [31:0] address;
    logic [31:0] seed_value;
    logic        load_seed;
    logic        init_state;
    logic        load_state;
    logic [31:0] val_connectivity;
    logic        load_connectivity;
    logic        run_en;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  kind;   // 0 seed, 1 state, 2 conn, 3 run
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];

    agent_config_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .address           (address),
        .seed_value        (seed_value),
        .load_seed         (load_seed),
        .init_state        (init_state),
        .load_state        (load_state),
        .val_connectivity  (val_connectivity),
        .load_connectivity (load_connectivity),
        .run_en            (run_en),
        .busy              (busy),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [1:0] op, input logic st, input logic [15:0] arg);
        return {op, 13'd0, st, arg};
    endfunction

    task automatic push(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic match(input logic [1:0] kind, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'(kind), 32'hFFFF_FFFF);
            return;
        end
        e = exp_q.pop_front();
        check("strobe_kind", 32'(kind), 32'(e.kind));
        if (kind != 2'd3) begin
            check("strobe_addr", address, e.addr);
            check("strobe_data", data, e.data);
        end
    endtask

    // Drive one word and hold it until the loader takes it (bounded).
    task automatic send(input logic [31:0] w);
        int t;
        t = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            check("ready_timeout", 32'(s_ready), 32'd1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  32'(s_ready), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_addr"},   address, 32'd0);
        check({tag, "_seed"},   seed_value, 32'd0);
        check({tag, "_conn"},   val_connectivity, 32'd0);
        check({tag, "_strobe"}, 32'({init_state, load_seed, load_state, load_connectivity, run_en}), 32'd0);
        check({tag, "_err"},    32'(err), 32'd0);
    endtask

    // Scoreboard monitor: every strobe/run cycle consumes one expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load_seed || load_state || load_connectivity) begin
                check("onehot", 32'($countones({load_seed, load_state, load_connectivity})), 32'd1);
            end
            if (load_seed)         match(2'd0, seed_value);
            if (load_state)        match(2'd1, 32'(init_state));
            if (load_connectivity) match(2'd2, val_connectivity);
            if (run_en) begin
                match(2'd3, 32'd0);
                check("ready_in_run", 32'(s_ready), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_idle", 32'(s_ready), 32'd1);

        // SEED addr 5
        push(2'd0, 32'd5, 32'hDEAD_BEEF);
        send(hdr(2'd0, 1'b0, 16'd5));
        send(32'hDEAD_BEEF);
        idle(1);
        check("seed_busy_after", 32'(busy), 32'd0);
        check("seed_addr_hold", address, 32'd5);

        // STATE addr 7 INF, then addr 9 SUS
        push(2'd1, 32'd7, 32'd1);
        send(hdr(2'd1, 1'b1, 16'd7));
        idle(1);
        check("state_ready", 32'(s_ready), 32'd1);
        check("state_busy", 32'(busy), 32'd0);
        push(2'd1, 32'd9, 32'd0);
        send(hdr(2'd1, 1'b0, 16'd9));
        idle(2);

        // CONN addr 3 with 2-cycle gaps between words
        for (int i = 1; i <= 4; i++) push(2'd2, 32'd3, 32'(i));
        send(hdr(2'd2, 1'b0, 16'd3));
        for (int i = 1; i <= 4; i++) begin
            idle(2);
            check("conn_busy_gap", 32'(busy), 32'd1);
            send(32'(i));
        end
        idle(2);

        // CONN back-to-back, then SEED with no bubble
        push(2'd2, 32'd40, 32'hA5A5_0000);
        push(2'd2, 32'd40, 32'h0000_5A5A);
        push(2'd2, 32'd40, 32'hFFFF_FFFF);
        push(2'd2, 32'd40, 32'h1234_5678);
        send(hdr(2'd2, 1'b0, 16'd40));
        send(32'hA5A5_0000);
        send(32'h0000_5A5A);
        send(32'hFFFF_FFFF);
        send(32'h1234_5678);
        w = $urandom;
        push(2'd0, 32'd12, w);
        send(hdr(2'd0, 1'b0, 16'd12));
        send(w);

        // RUN 10, then a STATE header that has to wait it out
        for (int i = 0; i < 10; i++) push(2'd3, 32'd0, 32'd0);
        send(hdr(2'd3, 1'b0, 16'd10));
        push(2'd1, 32'd2, 32'd1);
        send(hdr(2'd1, 1'b1, 16'd2));
        idle(2);
        check("run_drain", 32'(exp_q.size()), 32'd0);

        // RUN 0: no pulse, no busy
        send(hdr(2'd3, 1'b0, 16'd0));
        idle(1);
        check("run0_busy", 32'(busy), 32'd0);
        check("run0_run_en", 32'(run_en), 32'd0);
        idle(3);

`ifdef LOADER_ADDR_CHECK_EN
        // Out-of-range SEED and CONN: payload swallowed, err sticky
        send(hdr(2'd0, 1'b0, 16'd100));
        send(32'hCAFE_F00D);
        idle(2);
        check("err_set", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        send(hdr(2'd2, 1'b0, 16'd200));
        for (int i = 0; i < 4; i++) send(32'(i + 16));
        push(2'd0, 32'd1, 32'h0BAD_F00D);
        send(hdr(2'd0, 1'b0, 16'd1));
        send(32'h0BAD_F00D);
        idle(2);
        check("err_sticky", 32'(err), 32'd1);
`else
        // Without the range check, address 100 is loaded as usual
        push(2'd0, 32'd100, 32'hCAFE_F00D);
        send(hdr(2'd0, 1'b0, 16'd100));
        send(32'hCAFE_F00D);
        idle(2);
        check("err_tied_low", 32'(err), 32'd0);
`endif

        // Reset after the 2nd CONN word
        push(2'd2, 32'd3, 32'h0000_00AA);
        push(2'd2, 32'd3, 32'h0000_00BB);
        send(hdr(2'd2, 1'b0, 16'd3));
        send(32'h0000_00AA);
        send(32'h0000_00BB);
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("midreset_drain", 32'(exp_q.size()), 32'd0);

        // Fresh CONN after reset
        for (int i = 0; i < 4; i++) push(2'd2, 32'd3, 32'h100 + 32'(i));
        send(hdr(2'd2, 1'b0, 16'd3));
        for (int i = 0; i < 4; i++) send(32'h100 + 32'(i));
        idle(5);
        check("final_busy", 32'(busy), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
